// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings, FSM states and endianness default for the subword load/store unit.
package lsu_pkg;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;
   localparam bit BIG_ENDIAN_DEF = 1'b1;
   typedef enum logic [1:0] {IDLE, ACC, RMW_RD, RMW_WR} state_t;
endpackage

// File: rtl/lsu_lane_mux.sv
// lsu_lane_mux: lane extract/extend for loads and lane merge into a read word for stores.
module lsu_lane_mux
   import lsu_pkg::*;
#(
   parameter bit BIG_ENDIAN = BIG_ENDIAN_DEF
) (
   input  logic [1:0]  size,
   input  logic        unsign,
   input  logic [1:0]  off,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   input  logic [31:0] merge_base,
   output logic [31:0] load_data,
   output logic [31:0] store_data
);
   logic [4:0]  bsh, hsh;
   logic [7:0]  bsel;
   logic [15:0] hsel;
   // big-endian puts offset 0 in the most significant lane, so the shift is mirrored
   assign bsh  = {BIG_ENDIAN ? ~off : off, 3'b000};
   assign hsh  = {BIG_ENDIAN ? ~off[1] : off[1], 4'b0000};
   assign bsel = 8'(rdata >> bsh);
   assign hsel = 16'(rdata >> hsh);
   assign load_data = size == SZ_BYTE ? {{24{~unsign & bsel[7]}}, bsel} :
                      size == SZ_HALF ? {{16{~unsign & hsel[15]}}, hsel} : rdata;
   assign store_data = size == SZ_BYTE ? (merge_base & ~(32'h0000_00ff << bsh)) | ({24'd0, wdata[7:0]} << bsh) :
                       size == SZ_HALF ? (merge_base & ~(32'h0000_ffff << hsh)) | ({16'd0, wdata[15:0]} << hsh) : wdata;
endmodule

// File: rtl/lsu_subword_rmw.sv
// lsu_subword_rmw: MEM-stage load/store unit with subword read-modify-write; LSU_MISALIGN_TRAP_EN traps misaligned accesses.
module lsu_subword_rmw
   import lsu_pkg::*;
#(
   parameter bit BIG_ENDIAN = BIG_ENDIAN_DEF,
   parameter int ADDR_W     = 32
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              MemWre,
   output logic              MemRead,
   output logic [ADDR_W-1:0] DataAddress,
   output logic [31:0]       DataIn,
   input  logic [31:0]       DataOut
);
   state_t            state, next;
   logic              accept, err;
   logic              write_r, unsign_r;
   logic [1:0]        size_r;
   logic [ADDR_W-1:0] addr_r;
   logic [31:0]       wdata_r, merge_r, load_data, store_data;

   assign accept = req_valid && req_ready;
`ifdef LSU_MISALIGN_TRAP_EN
   assign err = req_size == SZ_ILL || (req_size == SZ_HALF && req_addr[0]) ||
                (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
`else
   // misaligned offsets fall away naturally: word ignores addr[1:0], half uses only addr[1]
   assign err = req_size == SZ_ILL;
`endif

   lsu_lane_mux #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
      .size(size_r),
      .unsign(unsign_r),
      .off(addr_r[1:0]),
      .rdata(DataOut),
      .wdata(wdata_r),
      .merge_base(merge_r),
      .load_data(load_data),
      .store_data(store_data)
   );

   always_ff @(posedge Clk)
      state <= Reset ? IDLE : next;

   always_comb begin
      next = IDLE;
      case (state)
         IDLE:    next = !accept || err ? IDLE : req_write && req_size != SZ_WORD ? RMW_RD : ACC;
         RMW_RD:  next = RMW_WR;
         default: next = IDLE;
      endcase
   end

   always_comb begin
      req_ready   = state == IDLE;
      MemRead     = (state == ACC && !write_r) || state == RMW_RD;
      MemWre      = (state == ACC && write_r) || state == RMW_WR;
      DataAddress = state == IDLE ? '0 : {addr_r[ADDR_W-1:2], 2'b00};
      DataIn      = MemWre ? store_data : 32'd0;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         write_r    <= 1'b0;
         unsign_r   <= 1'b0;
         size_r     <= SZ_BYTE;
         addr_r     <= '0;
         wdata_r    <= 32'd0;
         merge_r    <= 32'd0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'd0;
      end else begin
         if (accept) begin
            write_r  <= req_write;
            unsign_r <= req_unsigned;
            size_r   <= req_size;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
         end
         if (state == RMW_RD) merge_r <= DataOut;
         resp_valid <= (accept && err) || state == ACC || state == RMW_WR;
         resp_err   <= accept && err;
         resp_rdata <= state == ACC && !write_r ? load_data : 32'd0;
      end
   end
endmodule

// File: tb/tb_lsu_subword_rmw.sv
// tb_lsu_subword_rmw: random and directed requests checked against a byte-addressed memory model.
module tb_lsu_subword_rmw;
   localparam bit BE = 1'b1;
   logic        Clk = 0, Reset = 1;
   logic        req_valid = 0, req_ready, req_write = 0, req_unsigned = 0;
   logic [1:0]  req_size = 0;
   logic [31:0] req_addr = 0, req_wdata = 0;
   logic        resp_valid, resp_err, MemWre, MemRead;
   logic [31:0] resp_rdata, DataAddress, DataIn, DataOut;

   lsu_subword_rmw #(.BIG_ENDIAN(BE), .ADDR_W(32)) dut (
      .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .MemWre(MemWre), .MemRead(MemRead),
      .DataAddress(DataAddress), .DataIn(DataIn), .DataOut(DataOut)
   );

   always #5 Clk = ~Clk;

   logic [31:0] mem [16];
   initial for (int i = 0; i < 16; i++) mem[i] = 0;
   always @(posedge Clk) if (MemWre) mem[DataAddress[5:2]] <= DataIn;
   assign DataOut = mem[DataAddress[5:2]];

   typedef struct {logic [31:0] rdata; logic err; int cyc;} exp_t;
   exp_t q[$];
   logic [7:0] refb [64];
   initial for (int i = 0; i < 64; i++) refb[i] = 0;

   int tests = 0, fails = 0, cyc = 0, acc_cyc = 0;
   int wr_n = 0, rd_n = 0, last_wr_cyc = 0, last_rd_cyc = 0, last_resp_cyc = 0;
   logic [31:0] last_wr_addr = 0, last_wr_data = 0, last_rd_addr = 0, last_resp_rdata = 0;
   logic last_resp_err = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // spec-level model: memory as bytes, endianness decides which byte is most significant
   task automatic model(input bit w, input logic [1:0] sz, input bit u, input logic [5:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic er, output int lat);
      int n, base, idx;
      logic [31:0] v;
      er = sz == 2'b11;
`ifdef LSU_MISALIGN_TRAP_EN
      er = er || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 0);
`endif
      rd = 0;
      lat = er ? 1 : (w && sz != 2'b10) ? 3 : 2;
      if (!er) begin
         n = sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
         base = int'(a) & ~(n - 1);
         v = 0;
         for (int i = 0; i < n; i++) begin
            idx = BE ? base + i : base + n - 1 - i;
            if (w) refb[idx] = 8'(d >> (8 * (n - 1 - i)));
            else v = (v << 8) | {24'd0, refb[idx]};
         end
         if (!w) begin
            if (n < 4 && !u && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 1);
            rd = v;
         end
      end
   endtask

   always @(negedge Clk) if (!Reset) begin
      if (MemWre && MemRead) chk("wre_and_read", 1, 0);
      if (req_ready) chk("idle_mem_quiet", {30'd0, MemWre, MemRead}, 0);
      if (!req_ready) chk("addr_aligned", {30'd0, DataAddress[1:0]}, 0);
      if (MemWre) begin wr_n++; last_wr_addr = DataAddress; last_wr_data = DataIn; last_wr_cyc = cyc; end
      if (MemRead) begin rd_n++; last_rd_addr = DataAddress; last_rd_cyc = cyc; end
      if (resp_valid) begin
         last_resp_rdata = resp_rdata; last_resp_err = resp_err; last_resp_cyc = cyc;
         if (q.size() == 0) chk("unexpected_resp", 1, 0);
         else begin
            chk("resp_rdata", resp_rdata, q[0].rdata);
            chk("resp_err", {31'd0, resp_err}, {31'd0, q[0].err});
            chk("resp_cycle", cyc, q[0].cyc);
            void'(q.pop_front());
         end
      end else if (q.size() != 0 && cyc > q[0].cyc) begin
         chk("resp_missing", 0, 1);
         void'(q.pop_front());
      end
   end

   task automatic send(input bit w, input logic [1:0] sz, input bit u, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      logic [31:0] rd;
      logic er;
      int lat, t;
      @(negedge Clk);
      req_valid = 1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
      t = 0;
      while (!req_ready && t < 50) begin @(negedge Clk); t++; end
      if (!req_ready) begin chk("ready_timeout", 0, 1); req_valid = 0; return; end
      @(posedge Clk);
      acc_cyc = cyc;
      model(w, sz, u, a[5:0], d, rd, er, lat);
      e.rdata = rd; e.err = er; e.cyc = cyc + lat;
      q.push_back(e);
      #1 req_valid = 0;
   endtask

   task automatic drain;
      int t = 0;
      while (q.size() != 0 && t < 40) begin @(negedge Clk); #1; t++; end
      chk("drain", q.size(), 0);
   endtask

   initial begin
      int k, w0, r0;
      logic [31:0] w;
      req_valid = 1; req_write = 1; req_size = 0; req_addr = 32'h9; req_wdata = 32'hff;
      repeat (2) begin
         @(negedge Clk);
         chk("rst_ready", {31'd0, req_ready}, 1);
         chk("rst_resp_valid", {31'd0, resp_valid}, 0);
         chk("rst_mem_en", {30'd0, MemWre, MemRead}, 0);
         chk("rst_addr", DataAddress, 0);
      end
      req_valid = 0;
      Reset = 0;
      repeat (2) @(negedge Clk);
      chk("no_accept_in_reset", wr_n + rd_n, 0);

      send(1, 2'b10, 0, 32'd8, 32'h11223344); k = acc_cyc; drain;
      chk("sw_addr", last_wr_addr, 8);
      chk("sw_data", last_wr_data, 32'h11223344);
      chk("sw_wr_cyc", last_wr_cyc, k + 1);
      chk("sw_resp_cyc", last_resp_cyc, k + 2);
      send(0, 2'b10, 0, 32'd8, 0); drain;
      chk("lw_8", last_resp_rdata, 32'h11223344);

      send(1, 2'b00, 0, 32'd9, 32'h000000ab); k = acc_cyc;
      @(negedge Clk);
      chk("sb_ready_n1", {31'd0, req_ready}, 0);
      chk("sb_read_n1", {31'd0, MemRead}, 1);
      @(negedge Clk);
      chk("sb_ready_n2", {31'd0, req_ready}, 0);
      chk("sb_wre_n2", {31'd0, MemWre}, 1);
      chk("sb_datain", DataIn, 32'h11ab3344);
      drain;
      chk("sb_resp_cyc", last_resp_cyc, k + 3);

      send(0, 2'b00, 0, 32'd9, 0);  drain; chk("lb_9", last_resp_rdata, 32'hffffffab);
      send(0, 2'b00, 1, 32'd9, 0);  drain; chk("lbu_9", last_resp_rdata, 32'h000000ab);
      send(0, 2'b01, 0, 32'd10, 0); drain; chk("lh_10", last_resp_rdata, 32'h00003344);
      send(0, 2'b01, 0, 32'd8, 0);  drain; chk("lh_8", last_resp_rdata, 32'h000011ab);
      send(0, 2'b01, 1, 32'd8, 0);  drain; chk("lhu_8", last_resp_rdata, 32'h000011ab);

      r0 = rd_n;
      send(0, 2'b10, 0, 32'd1, 0); k = acc_cyc; drain;
`ifdef LSU_MISALIGN_TRAP_EN
      chk("mis_err", {31'd0, last_resp_err}, 1);
      chk("mis_cyc", last_resp_cyc, k + 1);
      chk("mis_no_read", rd_n, r0);
`else
      chk("mis_err", {31'd0, last_resp_err}, 0);
      chk("mis_rd_addr", last_rd_addr, 0);
      chk("mis_rd_cyc", last_rd_cyc, k + 1);
`endif

      send(1, 2'b11, 0, 32'd4, 32'hdeadbeef); drain;
      chk("ill_err", {31'd0, last_resp_err}, 1);

      w0 = wr_n;
      @(negedge Clk);
      req_valid = 1; req_write = 1; req_size = 2'b00; req_unsigned = 0; req_addr = 8; req_wdata = 32'hcd;
      @(posedge Clk); #1 req_valid = 0;
      @(negedge Clk);
      chk("rst_mid_read", {31'd0, MemRead}, 1);
      Reset = 1;
      @(negedge Clk);
      chk("rst_mid_wre", {31'd0, MemWre}, 0);
      chk("rst_mid_ready", {31'd0, req_ready}, 1);
      Reset = 0;
      repeat (3) @(negedge Clk);
      chk("rst_mid_no_write", wr_n, w0);
      chk("rst_mid_no_resp", {31'd0, resp_valid}, 0);
      send(0, 2'b10, 0, 32'd8, 0); drain;
      chk("lw_after_rst", last_resp_rdata, 32'h11ab3344);

      for (int i = 0; i < 400; i++)
         send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 63)), $urandom);
      drain;

      for (int i = 0; i < 16; i++) begin
         w = BE ? {refb[4*i], refb[4*i+1], refb[4*i+2], refb[4*i+3]}
                : {refb[4*i+3], refb[4*i+2], refb[4*i+1], refb[4*i]};
         chk("mem_final", mem[i], w);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected done");
      $fatal(1);
   end
endmodule
